// File: rtl/posenc_serial_add.sv
// Digit-serial adder/subtractor on one-hot (positional) encoded operands.
// Optional per-digit one-hot check enabled by defining POSENC_ONEHOT_CHECK_EN.
module posenc_serial_add #(
    parameter int RADIX  = 8,
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIGITS*RADIX-1:0]  a,
    input  logic [DIGITS*RADIX-1:0]  b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIGITS*RADIX-1:0]  sum,
    output logic [1:0]               cout,
    output logic                     err
);
    localparam int IW = (RADIX > 1) ? $clog2(RADIX) : 1;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W  = DIGITS * RADIX;
    localparam logic [CW-1:0] LAST    = CW'(DIGITS - 1);
    localparam logic [IW:0]   RADIX_W = (IW + 1)'(RADIX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            sub_q, carry_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      cout_q;
    logic            accept, handoff, last_digit;
    logic [RADIX-1:0] a_dig, b_dig, b_eff, s_dig;
    logic [IW-1:0]   ia, ib, s_idx;
    logic [IW:0]     s_full, s_wrap;
    logic            c_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        handoff = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN:  if (last_digit) state_d = DONE;
            DONE: if (out_ready) begin
                handoff = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign last_digit = (cnt_q == LAST);
    assign sum        = sum_q;
    assign cout       = cout_q;

    // Subtraction uses the radix complement: digit j becomes RADIX-1-j, which
    // in one-hot form is simply the bit-reversed digit; carry-in is forced to 1.
    always_comb begin
        a_dig = a_q[cnt_q*RADIX +: RADIX];
        b_dig = b_q[cnt_q*RADIX +: RADIX];
        ia    = '0;
        ib    = '0;
        b_eff = '0;
        s_dig = '0;
        for (int t = 0; t < RADIX; t++)
            b_eff[t] = sub_q ? b_dig[RADIX-1-t] : b_dig[t];
        for (int t = 0; t < RADIX; t++) begin
            if (a_dig[t]) ia = IW'(t);
            if (b_eff[t]) ib = IW'(t);
        end
        s_full = {1'b0, ia} + {1'b0, ib} + {{IW{1'b0}}, carry_q};
        s_wrap = s_full - RADIX_W;
        c_next = (s_full >= RADIX_W);
        s_idx  = c_next ? s_wrap[IW-1:0] : s_full[IW-1:0];
        for (int t = 0; t < RADIX; t++)
            s_dig[t] = (s_idx == IW'(t));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 2'b00;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[cnt_q*RADIX +: RADIX] <= s_dig;
            carry_q <= c_next;
            cnt_q   <= cnt_q + CW'(1);
            if (last_digit) cout_q <= {c_next, ~c_next};
        end else if (handoff) begin
            cout_q  <= 2'b00;
        end
    end

`ifdef POSENC_ONEHOT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if (state_q == RUN && (!$onehot(a_dig) || !$onehot(b_dig)))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_posenc_serial_add.sv
// Scoreboard bench for posenc_serial_add (RADIX=8, DIGITS=4): driver pushes
// hand-computed results, a negedge monitor pops and compares on each handoff.
module tb_posenc_serial_add;
    localparam int RADIX  = 8;
    localparam int DIGITS = 4;
    localparam int W      = RADIX * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic [1:0]   cout;
        logic         err;
        logic         care;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic [1:0]    cout;
    logic          err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    posenc_serial_add #(.RADIX(RADIX), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] oh(input logic [11:0] o);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++)
            r[k*RADIX + int'(o[3*k +: 3])] = 1'b1;
        return r;
    endfunction

    function automatic exp_t mk(input logic [11:0] s, input logic [1:0] c,
                                input logic e, input logic care);
        exp_t x;
        x.sum  = oh(s);
        x.cout = c;
        x.err  = e;
        x.care = care;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: result presented, got sum %0h expected none", sum);
            end else begin
                e = sb.pop_front();
                if (e.care) begin
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                end
                chk("err", err, e.err);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb_i, input int hold, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before", in_ready, 1);
        a = av; b = bv; cin = ci; sub = sb_i; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; cin = ~ci; sub = ~sb_i;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, DIGITS);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            if (e.care) begin
                chk("hold_sum", sum, e.sum);
                chk("hold_cout", cout, e.cout);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_cout", cout, 2'b00);
        chk("post_ready", in_ready, 1);
        if (e.care) chk("post_sum", sum, e.sum);
    endtask

    initial begin
        logic seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 2'b00);
        chk("rst_err", err, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", in_ready, 1);

        do_op(oh(12'o7777), oh(12'o0001), 1'b0, 1'b0, 0, mk(12'o0000, 2'b10, 1'b0, 1'b1));
        do_op(oh(12'o0005), oh(12'o0007), 1'b0, 1'b1, 0, mk(12'o7776, 2'b01, 1'b0, 1'b1));
        do_op(oh(12'o0007), oh(12'o0005), 1'b0, 1'b1, 1, mk(12'o0002, 2'b10, 1'b0, 1'b1));
        do_op(oh(12'o1234), oh(12'o4321), 1'b1, 1'b0, 3, mk(12'o5556, 2'b01, 1'b0, 1'b1));
        do_op(oh(12'o0003), oh(12'o0003), 1'b1, 1'b1, 0, mk(12'o0000, 2'b10, 1'b0, 1'b1));
        do_op(oh(12'o7777), oh(12'o7777), 1'b1, 1'b0, 2, mk(12'o7777, 2'b10, 1'b0, 1'b1));
        do_op(oh(12'o0000), oh(12'o0000), 1'b1, 1'b0, 0, mk(12'o0001, 2'b01, 1'b0, 1'b1));

        // Abort an operation with reset while digit 2 is in progress.
        a = oh(12'o3333); b = oh(12'o4444); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("abort_sum", sum, 0);
        chk("abort_valid", out_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", in_ready, 1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("abort_no_valid", seen, 0);
        do_op(oh(12'o0001), oh(12'o0001), 1'b0, 1'b0, 0, mk(12'o0002, 2'b01, 1'b0, 1'b1));

`ifdef POSENC_ONEHOT_CHECK_EN
        begin
            logic [W-1:0] bad;
            bad = oh(12'o0001);
            bad[7:0] = 8'b0000_0011;
            do_op(bad, oh(12'o0001), 1'b0, 1'b0, 1, mk(12'o0000, 2'b00, 1'b1, 1'b0));
            do_op(oh(12'o0001), oh(12'o0001), 1'b0, 1'b0, 0, mk(12'o0002, 2'b01, 1'b0, 1'b1));
        end
`endif

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/posenc_serial_add.md
POSENC_SERIAL_ADD -- requirements
Module: posenc_serial_add

Interface
REQ-001 RADIX, default 8, one-hot digit width (digit value d encoded as bit d set); legal RADIX >= 2.
REQ-002 DIGITS, default 4, digits per operand, least significant digit in bits [RADIX-1:0]; legal DIGITS >= 1.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operands, cin and sub present.
REQ-006 in_ready  out  1  block can accept an operation.
REQ-007 a  in  DIGITS*RADIX  operand A, one-hot per digit.
REQ-008 b  in  DIGITS*RADIX  operand B, one-hot per digit.
REQ-009 cin  in  1  carry-in; ignored when sub=1.
REQ-010 sub  in  1  0 = A+B+cin, 1 = A-B.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 sum  out  DIGITS*RADIX  result, one-hot per digit.
REQ-014 cout  out  2  one-hot carry {carry, no_carry}; in sub mode carry = no borrow.
REQ-015 err  out  1  malformed-digit flag (see Configuration).

Function
REQ-016 States: IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-017 IDLE: in_valid & in_ready captures a, b, sub, carry register (cin, or 1 when sub=1), clears digit counter, clears sum/err, -> RUN.
REQ-018 RUN: one digit k per cycle, k = 0..DIGITS-1; operand B digit j replaced by RADIX-1-j when sub=1.
REQ-019 Digit rule: sum digit k bit s set iff A digit i, B' digit j, s = (i+j+c) mod RADIX; next c = 1 iff i+j+c >= RADIX.
REQ-020 After digit DIGITS-1: cout = {c, ~c}, out_valid = 1, -> DONE; out_valid rises exactly DIGITS cycles after the accepting edge.
REQ-021 DONE: sum, cout, err, out_valid held stable while out_ready = 0.
REQ-022 DONE with out_ready = 1: out_valid, cout cleared next edge, -> IDLE; sum holds last value until next acceptance.
REQ-023 New operation never accepted in the same cycle as result handoff (no back-to-back; min period DIGITS+2 cycles).
REQ-024 in_valid, a, b changes while in RUN/DONE have no effect.
REQ-025 DIGITS = 1: RUN lasts one cycle; counter width max(1, clog2(DIGITS)).
REQ-026 Wrap-around: A+B overflow mod RADIX^DIGITS, signalled only via cout.

Reset
REQ-027 reset asserted: state = IDLE, in_ready = 1 once reset deasserts, out_valid = 0, sum = 0, cout = 2'b00, err = 0, carry and counter = 0.
REQ-028 reset during RUN or DONE aborts the operation; no partial result is presented.

Configuration
REQ-029 POSENC_ONEHOT_CHECK_EN defined: each processed A/B digit not exactly one-hot sets sticky err for the current operation, presented with out_valid; sum/cout for such digits are don't-care.
REQ-030 POSENC_ONEHOT_CHECK_EN undefined: no check logic, err tied 0.

Verification (RADIX=8, DIGITS=4, values octal, LSD rightmost)
REQ-031 add a=7777 b=0001 cin=0 -> sum=0000, cout={1,0}, out_valid 4 cycles after accept.
REQ-032 sub a=0005 b=0007 -> sum=7776, cout={0,1} (borrow); sub a=0007 b=0005 -> sum=0002, cout={1,0}.
REQ-033 add a=1234 b=4321 cin=1, out_ready low 3 cycles in DONE -> sum=5556, cout={0,1}, held stable, in_ready=0 until handoff.
REQ-034 reset pulse at RUN digit 2 -> out_valid never rises, sum=0, in_ready=1 next cycle; following add 0001+0001 -> 0002.
REQ-035 With POSENC_ONEHOT_CHECK_EN, a digit 0 = 8'b00000011 -> err=1 with out_valid; next clean operation -> err=0.
